// File: rtl/stereo_echo_engine_if.sv
// Audio frame handshake and external ring-buffer RAM bus for stereo_echo_engine.
// The engine connects through the slave modport. The codec-side and RAM-side logic uses the master modport.
interface stereo_echo_engine_if #(
  parameter int W  = 16,
  parameter int AW = 15
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_left;
  logic [W-1:0]  in_right;
  logic          out_valid;
  logic [W-1:0]  out_left;
  logic [W-1:0]  out_right;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  modport master (
    output in_valid, in_left, in_right, mem_rdata,
    input  in_ready, out_valid, out_left, out_right, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  in_valid, in_left, in_right, mem_rdata,
    output in_ready, out_valid, out_left, out_right, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/stereo_echo_engine.sv
// Stereo feedback-delay engine: per-frame read/compute/write pass over external per-channel ring buffers.
// Optional ECHO_CLEAR_EN: zero the whole RAM after reset before accepting frames.
module stereo_echo_engine #(
  parameter int W       = 16,
  parameter int AW      = 15,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               ADCLRCK,
  stereo_echo_engine_if.slave bus,
  input  logic [AW-1:0]      delay_time,
  input  logic [SHIFT_W-1:0] fb_shift,
  input  logic               bypass
);

  typedef enum logic [2:0] {
    IDLE, RD_L, RD_R, WR_L, WR_R, OUT
`ifdef ECHO_CLEAR_EN
    , CLEAR
`endif
  } state_t;

`ifdef ECHO_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
  localparam logic   RESET_READY = 1'b0;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   RESET_READY = 1'b1;
`endif

  state_t             state, state_n;
  logic [AW-1:0]      ptr, ptr_n, dt, dt_n;
  logic [SHIFT_W-1:0] sh, sh_n;
  logic               bp, bp_n;
  logic [W-1:0]       x_l, x_l_n, x_r, x_r_n, y_l, y_l_n, y_r, y_r_n;
  logic               ready, ready_n, ovalid, ovalid_n, we, we_n;
  logic [W-1:0]       o_l, o_l_n, o_r, o_r_n, wdata, wdata_n;
  logic [AW:0]        addr, addr_n;
`ifdef ECHO_CLEAR_EN
  logic [AW:0]        clr, clr_n;
`endif

  // y = sat(x + (echo >>> s)); a shift of W or more removes the echo entirely rather than leaving -1.
  function automatic logic [W-1:0] mix(input logic [W-1:0] x, input logic [W-1:0] e,
                                       input logic [SHIFT_W-1:0] s);
    logic signed [W-1:0] t;
    logic signed [W:0]   sum;
    if (int'(s) >= W) t = '0;
    else              t = $signed(e) >>> s;
    sum = $signed({x[W-1], x}) + $signed({t[W-1], t});
    if (sum[W] != sum[W-1]) mix = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                    mix = sum[W-1:0];
  endfunction

  assign bus.in_ready  = ready;
  assign bus.out_valid = ovalid;
  assign bus.out_left  = o_l;
  assign bus.out_right = o_r;
  assign bus.mem_addr  = addr;
  assign bus.mem_we    = we;
  assign bus.mem_wdata = wdata;

  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) state <= RESET_STATE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) begin
      ptr    <= '0;
      dt     <= '0;
      sh     <= '0;
      bp     <= 1'b0;
      x_l    <= '0;
      x_r    <= '0;
      y_l    <= '0;
      y_r    <= '0;
      ready  <= RESET_READY;
      ovalid <= 1'b0;
      o_l    <= '0;
      o_r    <= '0;
      addr   <= '0;
      we     <= 1'b0;
      wdata  <= '0;
`ifdef ECHO_CLEAR_EN
      clr    <= '0;
`endif
    end else begin
      ptr    <= ptr_n;
      dt     <= dt_n;
      sh     <= sh_n;
      bp     <= bp_n;
      x_l    <= x_l_n;
      x_r    <= x_r_n;
      y_l    <= y_l_n;
      y_r    <= y_r_n;
      ready  <= ready_n;
      ovalid <= ovalid_n;
      o_l    <= o_l_n;
      o_r    <= o_r_n;
      addr   <= addr_n;
      we     <= we_n;
      wdata  <= wdata_n;
`ifdef ECHO_CLEAR_EN
      clr    <= clr_n;
`endif
    end
  end

  // Outputs are registered. Each state computes the values the outputs must hold in the following state.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    dt_n     = dt;
    sh_n     = sh;
    bp_n     = bp;
    x_l_n    = x_l;
    x_r_n    = x_r;
    y_l_n    = y_l;
    y_r_n    = y_r;
    ready_n  = 1'b0;
    ovalid_n = 1'b0;
    o_l_n    = o_l;
    o_r_n    = o_r;
    addr_n   = addr;
    we_n     = 1'b0;
    wdata_n  = wdata;
`ifdef ECHO_CLEAR_EN
    clr_n    = clr;
`endif
    unique case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (bus.in_valid && ready) begin
          x_l_n   = bus.in_left;
          x_r_n   = bus.in_right;
          dt_n    = delay_time;
          sh_n    = fb_shift;
          bp_n    = bypass;
          addr_n  = {1'b0, ptr};
          ready_n = 1'b0;
          state_n = RD_L;
        end
      end
      RD_L: begin
        addr_n  = {1'b1, ptr};
        state_n = RD_R;
      end
      RD_R: begin
        // The left echo sample arrives from the RAM in this cycle.
        y_l_n   = bp ? x_l : mix(x_l, bus.mem_rdata, sh);
        addr_n  = {1'b0, ptr};
        wdata_n = y_l_n;
        we_n    = !bp;
        state_n = WR_L;
      end
      WR_L: begin
        y_r_n   = bp ? x_r : mix(x_r, bus.mem_rdata, sh);
        addr_n  = {1'b1, ptr};
        wdata_n = y_r_n;
        we_n    = !bp;
        state_n = WR_R;
      end
      WR_R: begin
        o_l_n    = y_l;
        o_r_n    = y_r;
        ovalid_n = 1'b1;
        state_n  = OUT;
      end
      OUT: begin
        if (!bp) ptr_n = (ptr >= dt) ? '0 : ptr + 1'b1;
        ready_n = 1'b1;
        state_n = IDLE;
      end
`ifdef ECHO_CLEAR_EN
      CLEAR: begin
        addr_n  = clr;
        wdata_n = '0;
        we_n    = 1'b1;
        clr_n   = clr + 1'b1;
        if (clr == '1) begin
          ready_n = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = RESET_STATE;
    endcase
  end

endmodule

// File: tb/tb_stereo_echo_engine.sv
// Self-checking bench for stereo_echo_engine against a per-channel ring-buffer reference model.
// Handles builds with and without ECHO_CLEAR_EN.
module tb_stereo_echo_engine;
  localparam int W       = 16;
  localparam int AW      = 4;
  localparam int SHIFT_W = 5;
  localparam int DEPTH   = 1 << AW;
  localparam int MEMN    = 1 << (AW + 1);
  localparam int MAXV    = (1 << (W - 1)) - 1;
  localparam int MINV    = -(1 << (W - 1));
`ifdef ECHO_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               ADCLRCK = 1'b0;
  logic [AW-1:0]      delay_time = '0;
  logic [SHIFT_W-1:0] fb_shift = '0;
  logic               bypass = 1'b0;

  stereo_echo_engine_if #(.W(W), .AW(AW)) bus ();

  stereo_echo_engine #(.W(W), .AW(AW), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .ADCLRCK(ADCLRCK), .bus(bus),
    .delay_time(delay_time), .fb_shift(fb_shift), .bypass(bypass)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous single port, one-cycle read latency, plus a backdoor bulk load.
  logic [W-1:0] ram [MEMN];
  logic [W-1:0] fill_val [MEMN];
  logic         fill_req = 1'b0;
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < MEMN; i++) ram[i] <= fill_val[i];
    end else if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel delay lines of past outputs and a frame pointer.
  int ring_l [DEPTH];
  int ring_r [DEPTH];
  int mptr;
  int t1_l [16];
  int t1_r [16];

  function automatic int rnd_s();
    logic [31:0]         u;
    logic signed [W-1:0] v;
    u = $urandom;
    v = u[W-1:0];
    return int'(v);
  endfunction

  function automatic int sat(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic int echo_term(input int e, input int s);
    if (s >= W) return 0;
    return e >>> s;
  endfunction

  task automatic model_frame(input int l, input int r, input int dt, input int sh, input int bp,
                             output int ol, output int orr, output int wp);
    wp = mptr;
    if (bp != 0) begin
      ol  = l;
      orr = r;
    end else begin
      ol  = sat(l + echo_term(ring_l[mptr], sh));
      orr = sat(r + echo_term(ring_r[mptr], sh));
      ring_l[mptr] = ol;
      ring_r[mptr] = orr;
      mptr = (mptr >= dt) ? 0 : mptr + 1;
    end
  endtask

  task automatic backdoor_load(input bit zero);
    int v;
    for (int i = 0; i < MEMN; i++) begin
      v = zero ? 0 : rnd_s();
      if (!zero && v == 0) v = 1;
      fill_val[i] = v[W-1:0];
      if (i < DEPTH) ring_l[i] = v;
      else           ring_r[i - DEPTH] = v;
    end
    @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  // Reset is asserted on entry; this task loads garbage, releases reset and brings the RAM and model to zero.
  task automatic release_reset();
    int lo;
    int nz;
    backdoor_load(1'b0);
    ADCLRCK = 1'b0;
    lo = 0;
    while (bus.in_ready !== 1'b1 && lo < MEMN + 20) begin
      lo++;
      @(negedge clk);
    end
    checks++;
    if (lo != (CLR_EN ? MEMN : 0))
      begin errors++; $display("FAIL ready_low_cycles: got %0d required %0d", lo, CLR_EN ? MEMN : 0); end
    @(negedge clk);
    @(negedge clk);
    if (CLR_EN) begin
      nz = 0;
      for (int i = 0; i < MEMN; i++) if (ram[i] !== '0) nz++;
      checks++;
      if (nz != 0) begin errors++; $display("FAIL clear_sweep: %0d nonzero words, required 0", nz); end
      for (int i = 0; i < DEPTH; i++) begin ring_l[i] = 0; ring_r[i] = 0; end
    end else begin
      backdoor_load(1'b1);
    end
    mptr = 0;
  endtask

  task automatic send_frame(input int l, input int r, input int dt, input int sh, input int bp,
                            output int ol, output int orr, output int obs_wp);
    int k, nw, el, er, wp;
    logic [AW:0]  wa0, wa1;
    logic [W-1:0] ew;
    k = 0;
    wa0 = '0;
    wa1 = '0;
    while (bus.in_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ready_wait: in_ready=%b required 1", bus.in_ready); end
    bus.in_left  = l[W-1:0];
    bus.in_right = r[W-1:0];
    delay_time   = dt[AW-1:0];
    fb_shift     = sh[SHIFT_W-1:0];
    bypass       = bp[0];
    bus.in_valid = 1'b1;
    model_frame(l, r, dt, sh, bp, el, er, wp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_left  = W'($urandom);
    bus.in_right = W'($urandom);
    delay_time   = AW'($urandom);
    fb_shift     = SHIFT_W'($urandom);
    bypass       = ~bypass;
    k = 1;
    nw = 0;
    obs_wp = -1;
    while (bus.out_valid !== 1'b1 && k < 20) begin
      if (bus.mem_we === 1'b1) begin
        if (nw == 0) wa0 = bus.mem_addr;
        else if (nw == 1) wa1 = bus.mem_addr;
        nw++;
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 5) begin errors++; $display("FAIL latency: out_valid after %0d cycles, required 5", k); end
    ew = el[W-1:0];
    checks++;
    if (bus.out_left !== ew)
      begin errors++; $display("FAIL out_left: got %0d required %0d", $signed(bus.out_left), el); end
    ew = er[W-1:0];
    checks++;
    if (bus.out_right !== ew)
      begin errors++; $display("FAIL out_right: got %0d required %0d", $signed(bus.out_right), er); end
    checks++;
    if (nw != ((bp != 0) ? 0 : 2))
      begin errors++; $display("FAIL write_count: got %0d required %0d", nw, (bp != 0) ? 0 : 2); end
    if (bp == 0 && nw == 2) begin
      checks++;
      if (wa0 !== {1'b0, wp[AW-1:0]} || wa1 !== {1'b1, wp[AW-1:0]})
        begin errors++; $display("FAIL write_addr: got %h/%h required ptr %0d", wa0, wa1, wp); end
      obs_wp = int'(wa0[AW-1:0]);
    end
    ol  = el;
    orr = er;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_pulse: got %b required 0", bus.out_valid); end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;
    #2 ADCLRCK = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== CLR_EN ? 1'b0 : 1'b1)
      begin errors++; $display("FAIL reset_in_ready: got %b required %b", bus.in_ready, !CLR_EN); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_left !== '0 || bus.out_right !== '0)
      begin errors++; $display("FAIL reset_out: got %b/%h/%h required 0/0/0", bus.out_valid, bus.out_left, bus.out_right); end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== '0)
      begin errors++; $display("FAIL reset_mem: got %h/%b/%h required 0/0/0", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
    release_reset();
  endtask

  task automatic test_impulse(input bit record);
    int ol, orr, wp, ex;
    for (int f = 0; f < 16; f++) begin
      send_frame((f == 0) ? 1000 : 0, 0, 3, 1, 0, ol, orr, wp);
      ex = (f == 0) ? 1000 : (f == 4) ? 500 : (f == 8) ? 250 : (f == 12) ? 125 : 0;
      checks++;
      if ($signed(bus.out_left) != ex || bus.out_right !== '0)
        begin errors++; $display("FAIL impulse f%0d: got %0d/%0d required %0d/0", f, $signed(bus.out_left), $signed(bus.out_right), ex); end
      if (record) begin
        t1_l[f] = $signed(bus.out_left);
        t1_r[f] = $signed(bus.out_right);
      end else begin
        checks++;
        if ($signed(bus.out_left) != t1_l[f] || $signed(bus.out_right) != t1_r[f])
          begin errors++; $display("FAIL impulse_repeat f%0d: got %0d/%0d required %0d/%0d", f, $signed(bus.out_left), $signed(bus.out_right), t1_l[f], t1_r[f]); end
      end
    end
  endtask

  task automatic test_saturation();
    int ol, orr, wp;
    backdoor_load(1'b1);
    for (int f = 0; f < 4; f++) begin
      send_frame(30000, 0, 0, 0, 0, ol, orr, wp);
      checks++;
      if ($signed(bus.out_left) != ((f == 0) ? 30000 : 32767))
        begin errors++; $display("FAIL sat_pos f%0d: got %0d required %0d", f, $signed(bus.out_left), (f == 0) ? 30000 : 32767); end
    end
    backdoor_load(1'b1);
    for (int f = 0; f < 4; f++) begin
      send_frame(-30000, 0, 0, 0, 0, ol, orr, wp);
      checks++;
      if ($signed(bus.out_left) != ((f == 0) ? -30000 : -32768))
        begin errors++; $display("FAIL sat_neg f%0d: got %0d required %0d", f, $signed(bus.out_left), (f == 0) ? -30000 : -32768); end
    end
    for (int f = 0; f < 12; f++)
      send_frame(rnd_s(), rnd_s(), $urandom_range(0, DEPTH - 1), $urandom_range(0, 3), 0, ol, orr, wp);
  endtask

  task automatic test_bypass();
    int ol, orr, wp, p0, l, r;
    p0 = mptr;
    for (int f = 0; f < 100; f++) begin
      l = rnd_s();
      r = rnd_s();
      send_frame(l, r, $urandom_range(0, DEPTH - 1), $urandom_range(0, 31), 1, ol, orr, wp);
      checks++;
      if ($signed(bus.out_left) != l || $signed(bus.out_right) != r)
        begin errors++; $display("FAIL bypass_data f%0d: got %0d/%0d required %0d/%0d", f, $signed(bus.out_left), $signed(bus.out_right), l, r); end
    end
    send_frame(rnd_s(), rnd_s(), DEPTH - 1, 2, 0, ol, orr, wp);
    checks++;
    if (wp != p0) begin errors++; $display("FAIL bypass_ptr_hold: got %0d required %0d", wp, p0); end
  endtask

  task automatic test_back_to_back();
    int acc, outs, cyc, last_acc, a, el, er, wp, sh, cl, cr;
    int q_cyc[$];
    int q_l[$];
    int q_r[$];
    bit accepted;
    acc = 0; outs = 0; cyc = 0; last_acc = -1;
    sh = $urandom_range(0, 3);
    cl = rnd_s();
    cr = rnd_s();
    @(negedge clk);
    delay_time   = 5;
    fb_shift     = sh[SHIFT_W-1:0];
    bypass       = 1'b0;
    bus.in_left  = cl[W-1:0];
    bus.in_right = cr[W-1:0];
    bus.in_valid = 1'b1;
    while ((acc < 20 || outs < acc) && cyc < 400) begin
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (q_cyc.size() == 0) begin
          errors++; $display("FAIL b2b_spurious_out: out_valid at cycle %0d with no frame pending", cyc);
        end else begin
          a  = q_cyc.pop_front();
          el = q_l.pop_front();
          er = q_r.pop_front();
          outs++;
          if (cyc - a != 5) begin errors++; $display("FAIL b2b_latency: got %0d required 5", cyc - a); end
          checks++;
          if (bus.out_left !== el[W-1:0] || bus.out_right !== er[W-1:0])
            begin errors++; $display("FAIL b2b_data: got %0d/%0d required %0d/%0d", $signed(bus.out_left), $signed(bus.out_right), el, er); end
        end
      end
      accepted = 1'b0;
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
        model_frame(cl, cr, 5, sh, 0, el, er, wp);
        q_cyc.push_back(cyc);
        q_l.push_back(el);
        q_r.push_back(er);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin errors++; $display("FAIL b2b_spacing: got %0d required 6", cyc - last_acc); end
        end
        last_acc = cyc;
        acc++;
        accepted = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (accepted) begin
        cl = rnd_s();
        cr = rnd_s();
        bus.in_left  = cl[W-1:0];
        bus.in_right = cr[W-1:0];
        if (acc == 20) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc != 20 || outs != 20)
      begin errors++; $display("FAIL b2b_count: accepted %0d outputs %0d required 20/20", acc, outs); end
  endtask

  task automatic test_reset_mid_pass();
    int k;
    while (bus.in_ready !== 1'b1) @(negedge clk);
    bus.in_left  = 16'd1234;
    bus.in_right = 16'd4321;
    delay_time   = 3;
    fb_shift     = 1;
    bypass       = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (bus.mem_we !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    checks++;
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL reach_wr_l: mem_we=%b required 1", bus.mem_we); end
    ADCLRCK = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b required 0", bus.mem_we); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_left !== '0 || bus.out_right !== '0)
      begin errors++; $display("FAIL abort_out: got %b/%h/%h required 0/0/0", bus.out_valid, bus.out_left, bus.out_right); end
    @(negedge clk);
    @(negedge clk);
    release_reset();
    test_impulse(1'b0);
  endtask

  task automatic test_prefill_delay_change();
    int ol, orr, wp, l, r, p, n;
    backdoor_load(1'b0);
    n = 0;
    do begin
      l = rnd_s(); r = rnd_s();
      send_frame(l, r, 7, 16, 0, ol, orr, wp);
      checks++;
      if ($signed(bus.out_left) != l || $signed(bus.out_right) != r)
        begin errors++; $display("FAIL muted_echo: got %0d/%0d required %0d/%0d", $signed(bus.out_left), $signed(bus.out_right), l, r); end
      n++;
    end while ((mptr < 4 || mptr > 7 || n < 3) && n < 16);
    p = mptr;
    send_frame(rnd_s(), rnd_s(), 2, 16, 0, ol, orr, wp);
    checks++;
    if (wp != p) begin errors++; $display("FAIL shrink_first: ptr %0d required %0d", wp, p); end
    send_frame(rnd_s(), rnd_s(), 2, 16, 0, ol, orr, wp);
    checks++;
    if (wp != 0) begin errors++; $display("FAIL shrink_wrap: ptr %0d required 0", wp); end
    for (int f = 0; f < 4; f++) send_frame(rnd_s(), rnd_s(), 2, 16, 0, ol, orr, wp);
  endtask

  initial begin
    test_reset();
    test_impulse(1'b1);
    test_saturation();
    test_bypass();
    test_back_to_back();
    test_reset_mid_pass();
    test_prefill_delay_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
